// File: rtl/inv_sqrt_iter.sv
// Iterative 1/sqrt(x) for IEEE-754 single: magic-constant seed refined by ITER
// Newton-Raphson steps on one shared 24x24 mantissa multiplier, valid/ready on both sides.
module inv_sqrt_iter #(
  parameter int unsigned ITER  = 2,
  parameter logic [31:0] MAGIC = 32'h5f3759df
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DataIn,
  input  logic        DataInValid,
  output logic        DataInReady,
  output logic [31:0] DataOut,
  output logic        DataOutValid,
  input  logic        DataOutReady,
  output logic [1:0]  Flags
);

  typedef enum logic [2:0] {IDLE, SEED, MUL_P, MUL_Q, SUB, MUL_Y, DONE} state_t;

  localparam logic [25:0] ONE_HALF = 26'h1800000;  // 1.5 in Q2.24

  state_t            state;
  logic [2:0]        cnt;
  logic [31:0]       x;
  logic signed [9:0] ye, pe, qe, re;
  logic [22:0]       yf, pf, qf, rf;
  logic              spec;
  logic [31:0]       spec_res;
  logic [1:0]        spec_flg;

  logic [7:0]        xexp;
  logic [22:0]       xman;
  logic              sp_c;
  logic [31:0]       sp_res_c;
  logic [1:0]        sp_flg_c;
  logic [30:0]       y0;
  logic signed [9:0] he;

  assign xexp = x[30:23];
  assign xman = x[22:0];
  assign y0   = 31'(MAGIC - (x >> 1));
  assign he   = $signed({2'b00, xexp}) - 10'sd1;

  always_comb begin
    sp_c     = 1'b1;
    sp_res_c = 32'h7fc00000;
    sp_flg_c = 2'b10;
    if (xexp == 8'h00) begin
      sp_res_c = {x[31], 31'h7f800000};
      sp_flg_c = 2'b01;
    end else if (xexp == 8'hff && xman != 23'd0) begin
      sp_flg_c = xman[22] ? 2'b00 : 2'b10;
    end else if (x[31]) begin
      sp_flg_c = 2'b10;
    end else if (xexp == 8'hff) begin
      sp_res_c = '0;
      sp_flg_c = 2'b00;
    end else begin
      sp_c = 1'b0;
    end
  end

  logic [23:0]       ma, mb;
  logic signed [9:0] mea, meb, me;
  logic [24:0]       mhi;
  logic [22:0]       mf;

  // Operand selection for the single shared multiplier
  always_comb begin
    ma  = {1'b1, yf};
    mb  = {1'b1, yf};
    mea = ye;
    meb = ye;
    case (state)
      MUL_Q: begin
        ma  = {1'b1, xman};
        mb  = {1'b1, pf};
        mea = he;
        meb = pe;
      end
      MUL_Y: begin
        mb  = {1'b1, rf};
        meb = re;
      end
      default: ;
    endcase
    mhi = 25'((48'(ma) * 48'(mb)) >> 23);
    mf  = mhi[24] ? mhi[23:1] : mhi[22:0];
    me  = mea + meb - 10'sd127 + (mhi[24] ? 10'sd1 : 10'sd0);
  end

  logic signed [9:0] qsh, se;
  logic [25:0]       qq, rr;
  logic [4:0]        lead;
  logic              clamp;
  logic [22:0]       sf;

  // r = 1.5 - q in Q2.24; q >= 1.5 clamps r to one LSB (2^-24)
  always_comb begin
    qq    = '0;
    rr    = 26'd1;
    lead  = '0;
    clamp = 1'b0;
    qsh   = 10'sd126 - qe;
    if (qe > 10'sd127)       clamp = 1'b1;
    else if (qe == 10'sd127) qq = {1'b0, 1'b1, qf, 1'b0};
    else if (qsh >= 10'sd24) qq = '0;
    else                     qq = {2'b00, {1'b1, qf} >> qsh[4:0]};
    if (!clamp && qq < ONE_HALF) rr = ONE_HALF - qq;
    for (int unsigned i = 0; i < 26; i++) begin
      if (rr[i]) lead = 5'(i);
    end
    if (lead == 5'd24) sf = rr[23:1];
    else               sf = 23'(rr << (5'd23 - lead));
    se = 10'sd103 + $signed({5'd0, lead});
  end

  logic [31:0] y_word;

  // Exponent guards are unreachable for normal inputs but keep the packing total
  always_comb begin
    if (ye > 10'sd254)     y_word = 32'h7f800000;
    else if (ye < 10'sd1)  y_word = '0;
    else                   y_word = {1'b0, ye[7:0], yf};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      x            <= '0;
      ye           <= '0;
      yf           <= '0;
      pe           <= '0;
      pf           <= '0;
      qe           <= '0;
      qf           <= '0;
      re           <= '0;
      rf           <= '0;
      spec         <= 1'b0;
      spec_res     <= '0;
      spec_flg     <= '0;
      DataInReady  <= 1'b0;
      DataOut      <= '0;
      DataOutValid <= 1'b0;
      Flags        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (DataInReady && DataInValid) begin
            x           <= DataIn;
            DataInReady <= 1'b0;
            state       <= SEED;
          end else begin
            DataInReady <= 1'b1;
          end
        end
        SEED: begin
          spec     <= sp_c;
          spec_res <= sp_res_c;
          spec_flg <= sp_flg_c;
          ye       <= $signed({2'b00, y0[30:23]});
          yf       <= y0[22:0];
          cnt      <= '0;
          state    <= (sp_c || ITER == 0) ? DONE : MUL_P;
        end
        MUL_P: begin
          pe    <= me;
          pf    <= mf;
          state <= MUL_Q;
        end
        MUL_Q: begin
          qe    <= me;
          qf    <= mf;
          state <= SUB;
        end
        SUB: begin
          re    <= se;
          rf    <= sf;
          state <= MUL_Y;
        end
        MUL_Y: begin
          ye <= me;
          yf <= mf;
          if (cnt == 3'(ITER - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt   <= cnt + 3'd1;
            state <= MUL_P;
          end
        end
        DONE: begin
          if (!DataOutValid) begin
            DataOutValid <= 1'b1;
            DataOut      <= spec ? spec_res : y_word;
            Flags        <= spec ? spec_flg : 2'b00;
          end else if (DataOutReady) begin
            DataOutValid <= 1'b0;
            DataInReady  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/inv_sqrt_iter.md
# inv_sqrt_iter

Parametrised successor to the single-shot fast inverse square root unit. Computes y ≈ 1/√x for IEEE-754 single-precision inputs: bit-trick seed plus ITER Newton–Raphson refinements on a shared mantissa multiplier. Adds valid/ready handshaking on both sides, IEEE special-case handling and exception flags. Sits in the float datapath between the operand source and result consumers, one operation in flight at a time.

## Interface
- ITER, 2, Newton iterations after seeding; legal 0..4
- MAGIC, 32'h5f3759df, seed constant

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- DataIn  in  32  operand x, IEEE-754 single
- DataInValid  in  1  operand present
- DataInReady  out  1  block can accept an operand
- DataOut  out  32  result, IEEE-754 single
- DataOutValid  out  1  result present
- DataOutReady  in  1  consumer accepts result
- Flags  out  2  [1] invalid, [0] divide-by-zero; qualified by DataOutValid

## Operation
- Accept when DataInValid && DataInReady; DataIn is captured into the x register.
- Classification in SEED (denormals flushed to zero):
  - ±0 or denormal -> signed Inf (0x7f800000 / 0xff800000), Flags=01.
  - NaN -> 0x7fc00000; Flags=10 only if signalling (mantissa bit 22 = 0).
  - Negative nonzero, including -Inf -> 0x7fc00000, Flags=10.
  - +Inf -> 0x00000000, Flags=00.
  - Special cases skip all iterations and go straight to DONE.
- Seed: y0 = MAGIC - (x >> 1), 32-bit unsigned subtract on raw bits.
- Newton step y' = y·(1.5 − h·y²), h = x/2 (exponent−1).
- The step runs as four states, one multiply or subtract each: MUL_P p=y·y; MUL_Q q=h·p; SUB r=1.5−q; MUL_Y y=y·r.
- Multiplies use one shared 24×24 mantissa multiplier (hidden bit included).
  - Product is normalised by 1 bit if ≥2, then truncated to 24 bits (round toward zero).
  - Exponents add with bias correction.
- SUB: q is aligned to unsigned Q2.24, r = 1.5 − q in Q2.24, then renormalised to float.
  - If q ≥ 1.5, r clamps to 2^-24 (never zero or negative).
- Iteration counter counts 0..ITER−1 and wraps to DONE after the last MUL_Y.
- FSM states: IDLE -> SEED -> (ITER=0 or special: DONE) else MUL_P -> MUL_Q -> SUB -> MUL_Y -> (count<ITER−1: MUL_P, else DONE).
- DONE -> IDLE on DataOutValid && DataOutReady.

## Timing
- Reset values: DataOut=0, DataOutValid=0, Flags=0, DataInReady=0. State=IDLE, counter=0.
- DataInReady is registered. It is 1 from the first cycle after rst deasserts, in IDLE only, and drops the cycle after accept.
- Latency: accept at edge k -> DataOutValid high after edge k+2+4·ITER. For special cases, k+2 regardless of ITER.
- DataOut and Flags are stable while DataOutValid && !DataOutReady, for unlimited stall.
- DataOutValid falls the cycle after the handshake. DataInReady rises in the same cycle, so there is one bubble cycle between results.
- rst mid-operation: the in-flight result is discarded, all outputs return to reset values next cycle, and no stale DataOutValid appears.
- DataIn/DataInValid are ignored when DataInReady=0.
- Throughput: one result per 3+4·ITER cycles when the consumer is always ready.

## Test plan
- ITER=0, DataIn=0x3f800000 (1.0) -> DataOut=0x3f7759df, Flags=00, DataOutValid exactly 2 cycles after accept.
- ITER=2, DataIn=0x3f800000 -> DataOut within ±64 ulp of 0x3f800000. DataIn=0x40800000 (4.0) -> within ±64 ulp of 0x3f000000. Latency 10 cycles.
- ITER=2, DataIn=0x3dcccccd (0.1) and 0x3efae148 (0.49) -> relative error ≤1e-5 against 3.16228 and 1.42857 (checked with a real-valued model).
- Special cases: 0x00000000->0x7f800000/01; 0x80000000->0xff800000/01; 0x00000001->0x7f800000/01; 0xbf800000->0x7fc00000/10; 0x7f800000->0x00000000/00; 0x7f800001->0x7fc00000/10; 0x7fc00000->0x7fc00000/00. Each at latency 2.
- Backpressure: hold DataOutReady=0 for 7 cycles after DataOutValid -> DataOut and Flags unchanged, DataInReady=0 throughout. Release -> next operand accepted one cycle later.
- Reset mid-iteration: assert rst for 1 cycle during MUL_Q of an ITER=2 op -> no DataOutValid for that op, DataInReady=1 the cycle after rst drops, and the next op (4.0) gives ≈0x3f000000.
